// File: rtl/param_multicycle_processor.sv
// Parametrised multi-cycle three-register ALU processor.
// Each instruction {op, rd, rs1, rs2} walks IDLE -> DECODE -> EXECUTE -> STORE.
// The debug port preloads and reads the register file.
module param_multicycle_processor #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 3
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0]    i_instr,
  input  logic                                i_valid,
  output logic                                o_ready,
  output logic                                o_done,
  output logic                                o_zero,
  output logic                                o_carry,
  input  logic                                i_dbg_we,
  input  logic [ADDR_WIDTH-1:0]               i_dbg_addr,
  input  logic [DATA_WIDTH-1:0]               i_dbg_wdata,
  output logic [DATA_WIDTH-1:0]               o_dbg_rdata
);

  localparam int IW    = OP_WIDTH + 3 * ADDR_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_STORE
  } state_e;

  state_e                  state_q;
  logic [IW-1:0]           instr_q;
  logic [DATA_WIDTH-1:0]   src1_q;
  logic [DATA_WIDTH-1:0]   src2_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    res_zero_q;
  logic                    res_carry_q;
  logic                    ready_q;
  logic                    done_q;
  logic                    zero_q;
  logic                    carry_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic [OP_WIDTH-1:0]     op;
  logic [ADDR_WIDTH-1:0]   rd;
  logic [ADDR_WIDTH-1:0]   rs1;
  logic [ADDR_WIDTH-1:0]   rs2;

  logic [DATA_WIDTH:0]     sum_d;
  logic [DATA_WIDTH:0]     diff_d;
  logic [SHW-1:0]          shamt_d;
  logic [DATA_WIDTH-1:0]   alu_res_d;
  logic                    alu_zero_d;
  logic                    alu_carry_d;

  assign op  = instr_q[IW-1 -: OP_WIDTH];
  assign rd  = instr_q[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign rs1 = instr_q[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign rs2 = instr_q[ADDR_WIDTH-1:0];

  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_zero      = zero_q;
  assign o_carry     = carry_q;
  assign o_dbg_rdata = rdata_q;

  // ALU: result, zero and carry/borrow from the latched operands.
  always_comb begin
    sum_d       = {1'b0, src1_q} + {1'b0, src2_q};
    diff_d      = {1'b0, src1_q} - {1'b0, src2_q};
    shamt_d     = src2_q[SHW-1:0];
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    case (op)
      OP_ADD:  {alu_carry_d, alu_res_d} = sum_d;
      OP_SUB:  {alu_carry_d, alu_res_d} = diff_d;
      OP_AND:  alu_res_d = src1_q & src2_q;
      OP_OR:   alu_res_d = src1_q | src2_q;
      OP_XOR:  alu_res_d = src1_q ^ src2_q;
      OP_SLL:  alu_res_d = src1_q << shamt_d;
      OP_SRL:  alu_res_d = src1_q >> shamt_d;
      default: alu_res_d = '0;
    endcase
    alu_zero_d = (alu_res_d == '0);
  end

  // Control FSM with registered handshake, done strobe and flags.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      result_q    <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            instr_q <= i_instr;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          src1_q <= regs[rs1];
          src2_q <= regs[rs2];
          if (op == OP_NOP) begin
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          result_q    <= alu_res_d;
          res_zero_q  <= alu_zero_d;
          res_carry_q <= alu_carry_d;
          state_q     <= S_STORE;
        end
        S_STORE: begin
          zero_q  <= res_zero_q;
          carry_q <= res_carry_q;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register file write: STORE result, or debug write while idle.
  // Gated by i_reset so an aborted instruction never writes back.
  always_ff @(posedge i_clock) begin
    if (i_reset && state_q == S_STORE) begin
      regs[rd] <= result_q;
    end else if (i_reset && state_q == S_IDLE && i_dbg_we) begin
      regs[i_dbg_addr] <= i_dbg_wdata;
    end
  end

  // Debug read port: old data on a same-edge write.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= regs[i_dbg_addr];
    end
  end

endmodule

// File: doc/param_multicycle_processor.md
Name: param_multicycle_processor

Overview:
Parametrised successor to the fixed-width multi-cycle Processor. It executes one three-register ALU instruction at a time over a four-state FSM. It adds a valid/ready instruction handshake, a done strobe, zero/carry flags, XOR and shift ops, and a debug port that preloads and reads the register file without hierarchical access. It sits between an instruction source (bench or future fetch unit) and nothing downstream; results live in the internal register file.

Parameters:
DATA_WIDTH, 32, register width in bits (>=8)
ADDR_WIDTH, 10, register address width; register count = 2**ADDR_WIDTH
OP_WIDTH, 3, opcode width; instruction = {op, rd, rs1, rs2}, width OP_WIDTH+3*ADDR_WIDTH

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  reset, asynchronous, active-low
i_instr  in  OP_WIDTH+3*ADDR_WIDTH  instruction {op, rd, rs1, rs2}
i_valid  in  1  instruction valid
o_ready  out 1  block idle, can accept an instruction
o_done   out 1  one-cycle pulse: instruction retired
o_zero   out 1  last ALU result == 0
o_carry  out 1  ADD carry-out / SUB borrow of last ALU op
i_dbg_we  in  1  debug write enable
i_dbg_addr  in  ADDR_WIDTH  debug read/write address
i_dbg_wdata  in  DATA_WIDTH  debug write data
o_dbg_rdata  out DATA_WIDTH  registered debug read data

Behaviour:
- Reset (i_reset=0, async): state=IDLE; o_ready=1; o_done=0; o_zero=0; o_carry=0; o_dbg_rdata=0. Any in-flight instruction is aborted with no register write. Register file contents are neither reset nor guaranteed.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL. Shift amount = low $clog2(DATA_WIDTH) bits of src2. All arithmetic is modulo 2**DATA_WIDTH, unsigned.
- FSM states IDLE, DECODE, EXECUTE, STORE.
  - IDLE: o_ready=1. On i_valid&&o_ready the instruction is latched and state moves to DECODE. Otherwise stay in IDLE.
  - DECODE: latch src1=reg[rs1] and src2=reg[rs2]. If op=NOP, go to IDLE and pulse o_done next cycle with no write and flags unchanged. Otherwise go to EXECUTE.
  - EXECUTE: compute the result into the result register, along with the zero flag and carry (ADD carry-out; SUB borrow = src1<src2). For logic/shift ops, carry=0. Go to STORE.
  - STORE: reg[rd] <= result at the end of the cycle. o_zero/o_carry update at the same edge. o_done=1 during the cycle after the write (state IDLE). Next state IDLE.
- Latency: accept at edge k; the write occurs at edge k+3; o_done is high in cycle k+3..k+4. The next instruction can be accepted at edge k+4 and observes the new value (rd==rs allowed, no hazard).
- o_ready is low in DECODE/EXECUTE/STORE. i_valid and i_instr are ignored while busy; a changing i_instr does not affect the latched instruction.
- Debug write: honoured only in IDLE. If i_dbg_we and an accept happen in the same cycle, both take effect, and the accepted instruction reads the debug-written value in DECODE. Debug writes while busy are dropped.
- Debug read: o_dbg_rdata <= reg[i_dbg_addr] every cycle. The read happens before any same-edge write (old data).
- rd == rs1 == rs2 is legal. Address wrap is not possible (full address space is implemented).

Test Plan:
- Reset mid-op: accept ADD rd=5, assert i_reset=0 during EXECUTE, release -> reg[5] unchanged, o_ready=1, o_done=0, flags 0.
- ADD overflow: dbg-write reg[1]=0xFFFFFFFF, reg[2]=1; ADD rd=3 rs1=1 rs2=2 -> reg[3]=0, o_zero=1, o_carry=1, o_done pulses 4 cycles after accept.
- SUB borrow plus shift: reg[4]=5, reg[6]=7; SUB rd=7 rs1=4 rs2=6 -> 0xFFFFFFFE, carry=1, zero=0. Then SLL with src1=1, src2=36 -> result 0x10, carry=0.
- Dependent chain: reg[1020]=0x0F0F, reg[1019]=0x00FF; XOR rd=1020 rs1=1020 rs2=1019, then OR rd=1018 rs1=1020 rs2=1020 back-to-back -> reg[1020]=0x0FF0, reg[1018]=0x0FF0.
- Handshake: hold i_valid=1 and change i_instr every cycle while busy -> exactly one instruction retires per 4 cycles. Only instructions present when o_ready=1 execute; o_ready=0 for exactly 3 cycles per ALU op.
- NOP plus debug: NOP accepted -> o_done pulse after 2 cycles, flags and registers unchanged. Debug write while busy -> dropped, verified via o_dbg_rdata.
